// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU opcodes, sequencing-controller state encoding and register-port
// source helpers used by the hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_JMP  = 4'hC,
    OP_CALL = 4'hD,
    OP_RET  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_RET_WAIT,
    ST_DRAIN,
    ST_HALTED
  } ctrl_state_t;

  localparam logic [3:0] SP_REG           = 4'hE;
  localparam int         RET_TIMEOUT_DEF  = 8;
  localparam int         DRAIN_CYCLES_DEF = 3;

  // Loads and stores address memory through SP on port0 instead of rs.
  function automatic logic [3:0] port0_src(input logic load_store, input logic [3:0] rs);
    return load_store ? SP_REG : rs;
  endfunction

  function automatic logic [3:0] port1_src(input logic read_rd, input logic [3:0] rt,
                                           input logic [3:0] rd);
    return read_rd ? rd : rt;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: resolves which registers the ID instruction
// actually reads and compares them against the destination of a load in EX.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       i_id_r0_used,
  input  logic       i_id_r1_used,
  input  logic [3:0] i_id_rs,
  input  logic [3:0] i_id_rt,
  input  logic [3:0] i_id_rd,
  input  logic       i_id_read_rd,
  input  logic       i_id_load_store,
  input  logic       i_ex_mem_read,
  input  logic [3:0] i_ex_rd,
  output logic       o_load_use
);

  logic [3:0] w_p0_src;
  logic [3:0] w_p1_src;
  logic       w_p0_hit;
  logic       w_p1_hit;

  assign w_p0_src   = port0_src(i_id_load_store, i_id_rs);
  assign w_p1_src   = port1_src(i_id_read_rd, i_id_rt, i_id_rd);
  assign w_p0_hit   = i_id_r0_used && (i_ex_rd == w_p0_src);
  assign w_p1_hit   = i_id_r1_used && (i_ex_rd == w_p1_src);
  assign o_load_use = i_ex_mem_read && (w_p0_hit || w_p1_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: combinational stall/flush decisions plus a
// registered FSM that sequences RET waits and HLT drains.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RET_TIMEOUT  = RET_TIMEOUT_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_id_op,
  input  logic [3:0] i_id_rs,
  input  logic [3:0] i_id_rt,
  input  logic [3:0] i_id_rd,
  input  logic       i_id_r0_used,
  input  logic       i_id_r1_used,
  input  logic       i_id_read_rd,
  input  logic       i_id_load_store,
  input  logic       i_ex_mem_read,
  input  logic [3:0] i_ex_rd,
  input  logic       i_mem_branch_taken,
  input  logic       i_ret_done,
  output logic       o_pc_we,
  output logic       o_if_id_we,
  output logic       o_if_id_flush,
  output logic       o_id_ex_bubble,
  output logic       o_ex_mem_flush,
  output logic       o_halted,
  output logic       o_err
);

  localparam int RW = $clog2(RET_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [RW-1:0] RET_LAST   = RW'(RET_TIMEOUT - 1);
  localparam logic [RW-1:0] RET_SAT    = RW'(RET_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  ctrl_state_t   r_state;
  logic [RW-1:0] r_ret_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic          r_halted;
  logic          r_err;

  opcode_t w_op;
  logic    w_load_use;

  assign w_op = opcode_t'(i_id_op);

  load_use_detect u_load_use (
    .i_id_r0_used    (i_id_r0_used),
    .i_id_r1_used    (i_id_r1_used),
    .i_id_rs         (i_id_rs),
    .i_id_rt         (i_id_rt),
    .i_id_rd         (i_id_rd),
    .i_id_read_rd    (i_id_read_rd),
    .i_id_load_store (i_id_load_store),
    .i_ex_mem_read   (i_ex_mem_read),
    .i_ex_rd         (i_ex_rd),
    .o_load_use      (w_load_use)
  );

  // A taken branch outranks every state action so it can kill a younger RET or HLT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_ret_cnt   <= '0;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else if (r_state != ST_HALTED) begin
      if (i_mem_branch_taken) begin
        r_state     <= ST_RUN;
        r_ret_cnt   <= '0;
        r_drain_cnt <= '0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (!w_load_use && (w_op == OP_RET)) begin
              r_state   <= ST_RET_WAIT;
              r_ret_cnt <= '0;
            end else if (!w_load_use && (w_op == OP_HLT)) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
            end
          end
          ST_RET_WAIT: begin
            if (i_ret_done) begin
              r_state   <= ST_RUN;
              r_ret_cnt <= '0;
            end else if (r_ret_cnt == RET_LAST) begin
              r_state   <= ST_RUN;
              r_ret_cnt <= '0;
              r_err     <= 1'b1;
            end else if (r_ret_cnt != RET_SAT) begin
              r_ret_cnt <= r_ret_cnt + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (r_drain_cnt == '0) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt - 1'b1;
            end
          end
          default: r_state <= ST_RUN;
        endcase
      end
    end
  end

  always_comb begin
    o_pc_we        = 1'b1;
    o_if_id_we     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_ex_mem_flush = 1'b0;
    if (r_state == ST_HALTED) begin
      o_pc_we        = 1'b0;
      o_if_id_we     = 1'b0;
      o_id_ex_bubble = 1'b1;
    end else if (i_mem_branch_taken) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      o_ex_mem_flush = 1'b1;
    end else begin
      case (r_state)
        ST_RET_WAIT: begin
          o_pc_we        = i_ret_done;
          o_if_id_flush  = 1'b1;
          o_id_ex_bubble = 1'b1;
        end
        ST_DRAIN: begin
          o_pc_we        = 1'b0;
          o_if_id_we     = 1'b0;
          o_id_ex_bubble = 1'b1;
        end
        default: begin
          if (w_load_use || (w_op == OP_HLT)) begin
            o_pc_we        = 1'b0;
            o_if_id_we     = 1'b0;
            o_id_ex_bubble = 1'b1;
          end else if (w_op == OP_RET) begin
            o_pc_we       = 1'b0;
            o_if_id_flush = 1'b1;
          end else if (w_op == OP_CALL) begin
            o_if_id_flush = 1'b1;
          end
        end
      endcase
    end
  end

  assign o_halted = r_halted;
  assign o_err    = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table vectors in RUN, directed
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int RET_TIMEOUT  = 8;
  localparam int DRAIN_CYCLES = 3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Expected outputs packed as {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush}
  localparam logic [4:0] EXP_NORM    = 5'b11000;
  localparam logic [4:0] EXP_STALL   = 5'b00010;
  localparam logic [4:0] EXP_CALL    = 5'b11100;
  localparam logic [4:0] EXP_BR      = 5'b11111;
  localparam logic [4:0] EXP_RETID   = 5'b01100;
  localparam logic [4:0] EXP_RETW    = 5'b01110;
  localparam logic [4:0] EXP_RETDONE = 5'b11110;

  localparam int M_RUN = 0, M_RETW = 1, M_DRAIN = 2, M_HALT = 3;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
    logic       r0u;
    logic       r1u;
    logic       readRd;
    logic       ls;
    logic       exRead;
    logic [3:0] exRd;
    logic       br;
    logic       retDone;
  } in_t;

  typedef struct {
    in_t        stim;
    logic [4:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_op, id_rs, id_rt, id_rd, ex_rd;
  logic       id_r0_used, id_r1_used, id_read_rd, id_load_store, ex_mem_read;
  logic       mem_branch_taken, ret_done;
  logic       pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush, halted, err;

  int numChecks = 0;
  int numFails  = 0;

  int mMode, mWaited, mHltAge;
  bit mHalted, mErr;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .RET_TIMEOUT  (RET_TIMEOUT),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_id_op            (id_op),
    .i_id_rs            (id_rs),
    .i_id_rt            (id_rt),
    .i_id_rd            (id_rd),
    .i_id_r0_used       (id_r0_used),
    .i_id_r1_used       (id_r1_used),
    .i_id_read_rd       (id_read_rd),
    .i_id_load_store    (id_load_store),
    .i_ex_mem_read      (ex_mem_read),
    .i_ex_rd            (ex_rd),
    .i_mem_branch_taken (mem_branch_taken),
    .i_ret_done         (ret_done),
    .o_pc_we            (pc_we),
    .o_if_id_we         (if_id_we),
    .o_if_id_flush      (if_id_flush),
    .o_id_ex_bubble     (id_ex_bubble),
    .o_ex_mem_flush     (ex_mem_flush),
    .o_halted           (halted),
    .o_err              (err)
  );

  function automatic in_t mk(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                             input logic [3:0] rd, input logic r0u, input logic r1u,
                             input logic readRd, input logic ls, input logic exRead,
                             input logic [3:0] exRd, input logic br, input logic retDone);
    in_t s;
    s.op = op; s.rs = rs; s.rt = rt; s.rd = rd;
    s.r0u = r0u; s.r1u = r1u; s.readRd = readRd; s.ls = ls;
    s.exRead = exRead; s.exRd = exRd; s.br = br; s.retDone = retDone;
    return s;
  endfunction

  task automatic applyStimulus(input in_t s);
    id_op = s.op; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    id_r0_used = s.r0u; id_r1_used = s.r1u; id_read_rd = s.readRd;
    id_load_store = s.ls; ex_mem_read = s.exRead; ex_rd = s.exRd;
    mem_branch_taken = s.br; ret_done = s.retDone;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] exp,
                             input logic expHalted, input logic expErr);
    logic [6:0] act;
    logic [6:0] want;
    act  = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_flush, halted, err};
    want = {exp, expHalted, expErr};
    numChecks++;
    if (act !== want) begin
      numFails++;
      $display("[TB] FAIL %s: got %b, expected %b (pc,ifid,flush,bubble,exflush,halted,err)",
               name, act, want);
    end
  endtask

  // One clock cycle: drive, settle, compare combinational outputs, then clock.
  task automatic step(input string name, input in_t s, input logic [4:0] exp,
                      input logic expHalted, input logic expErr);
    applyStimulus(s);
    #2;
    checkOutput(name, exp, expHalted, expErr);
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1; returns released, before the next edge.
  task automatic doReset(input string name);
    applyStimulus(mk(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #2;
    checkOutput(name, EXP_NORM, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic bit modelLoadUse(input in_t s);
    int p0, p1;
    p0 = s.ls ? 14 : int'(s.rs);
    p1 = s.readRd ? int'(s.rd) : int'(s.rt);
    return s.exRead && ((s.r0u && int'(s.exRd) == p0) || (s.r1u && int'(s.exRd) == p1));
  endfunction

  function automatic logic [4:0] modelOut(input in_t s);
    if (mMode == M_HALT) return EXP_STALL;
    if (s.br) return EXP_BR;
    if (mMode == M_RETW) return s.retDone ? EXP_RETDONE : EXP_RETW;
    if (mMode == M_DRAIN) return EXP_STALL;
    if (modelLoadUse(s)) return EXP_STALL;
    if (s.op == OP_RET) return EXP_RETID;
    if (s.op == OP_HLT) return EXP_STALL;
    if (s.op == OP_CALL) return EXP_CALL;
    return EXP_NORM;
  endfunction

  task automatic modelReset();
    mMode = M_RUN; mWaited = 0; mHltAge = 0; mHalted = 0; mErr = 0;
  endtask

  // Waiting and draining are tracked as elapsed cycles since the RET/HLT left ID.
  task automatic modelAdvance(input in_t s);
    if (mMode == M_HALT) return;
    if (s.br) begin
      mMode = M_RUN; mWaited = 0; mHltAge = 0;
      return;
    end
    case (mMode)
      M_RUN: begin
        if (!modelLoadUse(s) && s.op == OP_RET) begin
          mMode = M_RETW; mWaited = 0;
        end else if (!modelLoadUse(s) && s.op == OP_HLT) begin
          mMode = M_DRAIN; mHltAge = 1;
        end
      end
      M_RETW: begin
        mWaited++;
        if (s.retDone) mMode = M_RUN;
        else if (mWaited == RET_TIMEOUT) begin
          mErr = 1; mMode = M_RUN;
        end
      end
      default: begin
        mHltAge++;
        if (mHltAge == DRAIN_CYCLES + 1) begin
          mMode = M_HALT; mHalted = 1;
        end
      end
    endcase
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[14];
    in_t  idle, retIn, hltIn, brIn, doneIn;
    int   haltedFor;

    idle   = mk(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    retIn  = mk(OP_RET, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hltIn  = mk(OP_HLT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    brIn   = mk(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    doneIn = mk(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    vecs[0]  = '{mk(OP_ADD, 3, 1, 5, 1, 1, 0, 0, 1, 3, 0, 0), EXP_STALL};
    vecs[1]  = '{mk(OP_ADD, 3, 1, 5, 1, 1, 0, 0, 0, 3, 0, 0), EXP_NORM};
    vecs[2]  = '{mk(OP_SW, 2, 0, 7, 1, 1, 1, 1, 1, 4'hE, 0, 0), EXP_STALL};
    vecs[3]  = '{mk(OP_SW, 2, 0, 7, 1, 1, 1, 1, 1, 2, 0, 0), EXP_NORM};
    vecs[4]  = '{mk(OP_ADD, 0, 6, 1, 0, 1, 0, 0, 1, 6, 0, 0), EXP_STALL};
    vecs[5]  = '{mk(OP_ADD, 0, 1, 6, 0, 1, 1, 0, 1, 6, 0, 0), EXP_STALL};
    vecs[6]  = '{mk(OP_ADD, 0, 6, 1, 0, 1, 1, 0, 1, 6, 0, 0), EXP_NORM};
    vecs[7]  = '{mk(OP_ADD, 5, 0, 0, 0, 1, 0, 0, 1, 5, 0, 0), EXP_NORM};
    vecs[8]  = '{mk(OP_CALL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), EXP_CALL};
    vecs[9]  = '{mk(OP_CALL, 4, 0, 0, 1, 0, 0, 0, 1, 4, 0, 0), EXP_STALL};
    vecs[10] = '{mk(OP_ADD, 3, 1, 5, 1, 1, 0, 0, 1, 3, 1, 0), EXP_BR};
    vecs[11] = '{mk(OP_RET, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), EXP_BR};
    vecs[12] = '{mk(OP_HLT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), EXP_BR};
    vecs[13] = '{idle, EXP_NORM};

    rst_n = 1'b0;
    applyStimulus(idle);
    @(posedge clk);
    #1;
    doReset("reset_defaults");

    for (int i = 0; i < 14; i++) step($sformatf("vec%0d", i), vecs[i].stim, vecs[i].exp, 1'b0, 1'b0);

    // RET answered on the third wait cycle: four flushed fetches.
    step("retB_id", retIn, EXP_RETID, 1'b0, 1'b0);
    step("retB_w1", idle, EXP_RETW, 1'b0, 1'b0);
    step("retB_w2", idle, EXP_RETW, 1'b0, 1'b0);
    step("retB_done", doneIn, EXP_RETDONE, 1'b0, 1'b0);
    step("retB_after", idle, EXP_NORM, 1'b0, 1'b0);

    // ret_done on the final wait cycle beats the timeout.
    step("retD_id", retIn, EXP_RETID, 1'b0, 1'b0);
    for (int k = 1; k < RET_TIMEOUT; k++) step($sformatf("retD_w%0d", k), idle, EXP_RETW, 1'b0, 1'b0);
    step("retD_done", doneIn, EXP_RETDONE, 1'b0, 1'b0);
    step("retD_after", idle, EXP_NORM, 1'b0, 1'b0);

    // Timeout: err appears after RET_TIMEOUT wait cycles and sticks.
    step("retC_id", retIn, EXP_RETID, 1'b0, 1'b0);
    for (int k = 1; k <= RET_TIMEOUT; k++) step($sformatf("retC_w%0d", k), idle, EXP_RETW, 1'b0, 1'b0);
    step("retC_err", idle, EXP_NORM, 1'b0, 1'b1);
    step("retC_sticky", idle, EXP_NORM, 1'b0, 1'b1);
    doReset("retC_reset");

    // Branch in the first wait cycle cancels the RET entirely.
    step("retE_id", retIn, EXP_RETID, 1'b0, 1'b0);
    step("retE_br", brIn, EXP_BR, 1'b0, 1'b0);
    for (int k = 0; k <= RET_TIMEOUT; k++) step($sformatf("retE_run%0d", k), idle, EXP_NORM, 1'b0, 1'b0);

    // HLT drains, halts on the fourth cycle and ignores branches afterwards.
    step("hlt_id", hltIn, EXP_STALL, 1'b0, 1'b0);
    for (int k = 1; k <= DRAIN_CYCLES; k++) step($sformatf("hlt_drain%0d", k), idle, EXP_STALL, 1'b0, 1'b0);
    step("hlt_halted", idle, EXP_STALL, 1'b1, 1'b0);
    step("hlt_br_ignored", brIn, EXP_STALL, 1'b1, 1'b0);
    step("hlt_ret_ignored", retIn, EXP_STALL, 1'b1, 1'b0);
    doReset("hlt_reset");

    // Asynchronous reset in the middle of a drain.
    step("hltG_id", hltIn, EXP_STALL, 1'b0, 1'b0);
    applyStimulus(idle);
    #2;
    checkOutput("hltG_drain", EXP_STALL, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("hltG_async_rst", EXP_NORM, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("hltG_after", idle, EXP_NORM, 1'b0, 1'b0);

    // Branch during drain aborts the halt.
    step("hltH_id", hltIn, EXP_STALL, 1'b0, 1'b0);
    step("hltH_br", brIn, EXP_BR, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step($sformatf("hltH_run%0d", k), idle, EXP_NORM, 1'b0, 1'b0);

    doReset("rand_reset");
    modelReset();
    haltedFor = 0;
    for (int i = 0; i < 600; i++) begin
      in_t s;
      if (mHalted) haltedFor++;
      if (haltedFor > 3) begin
        @(posedge clk);
        #1;
        doReset($sformatf("rand_reset%0d", i));
        modelReset();
        haltedFor = 0;
      end
      s.op = 4'($urandom_range(0, 15));
      if (s.op == OP_HLT && $urandom_range(0, 3) != 0) s.op = OP_ADD;
      s.rs      = 4'($urandom_range(0, 3));
      s.rt      = 4'($urandom_range(0, 3));
      s.rd      = 4'($urandom_range(0, 3));
      s.r0u     = 1'($urandom_range(0, 1));
      s.r1u     = 1'($urandom_range(0, 1));
      s.readRd  = 1'($urandom_range(0, 1));
      s.ls      = 1'($urandom_range(0, 1));
      s.exRead  = (s.op == OP_HLT) ? 1'b0 : 1'($urandom_range(0, 1));
      s.exRd    = ($urandom_range(0, 4) == 0) ? 4'hE : 4'($urandom_range(0, 3));
      s.br      = ($urandom_range(0, 15) == 0);
      s.retDone = ($urandom_range(0, 3) == 0);
      applyStimulus(s);
      #2;
      checkOutput($sformatf("rand%0d", i), modelOut(s), mHalted, mErr);
      @(posedge clk);
      modelAdvance(s);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
